// File: rtl/jag_dram_sched.sv
// Two-master scheduler for the Jaguar DRAM channel ch1: round-robin arbitration,
// open-row tracking, periodic refresh and pch/act/reqr/reqw pulse sequencing.
module jag_dram_sched #(
   parameter int T_ACT        = 4,
   parameter int T_PCH        = 4,
   parameter int T_RD         = 8,
   parameter int T_WR         = 5,
   parameter int T_REF        = 9,
   parameter int REF_INTERVAL = 780
) (
   input  logic        clk,
   input  logic        init_n,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic [19:0] m0_addr,
   input  logic [19:0] m1_addr,
   input  logic        m0_rnw,
   input  logic        m1_rnw,
   input  logic [63:0] m0_din,
   input  logic [63:0] m1_din,
   input  logic [7:0]  m0_be,
   input  logic [7:0]  m1_be,
   output logic        m0_ack,
   output logic        m1_ack,
   output logic [63:0] rd_data,
   output logic [7:0]  ch1_addr,
   output logic [12:0] ch1_caddr,
   output logic [63:0] ch1_din,
   output logic [7:0]  ch1_be,
   output logic        ch1_reqr,
   output logic        ch1_reqw,
   output logic        ch1_act,
   output logic        ch1_pch,
   output logic        ch1_ref,
   output logic        ch1_rnw,
   output logic        ch1_64,
   input  logic [63:0] ch1_dout,
   output logic        row_open,
   output logic [11:0] open_row
);

   typedef enum logic [2:0] {IDLE, PCH, ACT, RD, WR, REF} state_t;

   state_t      state;
   state_t      next_state;
   state_t      ret_state;
   state_t      ret_next;
   logic        boot;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_cnt_d;
   logic [9:0]  ref_cnt;
   logic        ref_pend;
   logic        last_gnt;
   logic        gnt;
   logic [19:0] lat_addr;
   logic        lat_rnw;
   logic [63:0] lat_din;
   logic [7:0]  lat_be;
   logic        win;
   logic        grant;
   logic [19:0] win_addr;
   logic        win_rnw;
   logic [63:0] win_din;
   logic [7:0]  win_be;
   logic [19:0] cur_addr;
   logic        cur_rnw;
   logic [63:0] cur_din;
   logic [7:0]  cur_be;
   logic        enter;
   logic        done;

   assign ch1_64 = 1'b1;

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state     <= IDLE;
         ret_state <= IDLE;
      end else begin
         state     <= next_state;
         ret_state <= ret_next;
      end
   end

   // Requests are ignored during an ack cycle: the acked master still holds its old request.
   always_comb begin
      next_state = state;
      ret_next   = ret_state;
      grant      = 1'b0;
      win        = (m0_req && m1_req) ? ~last_gnt : m1_req;
      win_addr   = win ? m1_addr : m0_addr;
      win_rnw    = win ? m1_rnw  : m0_rnw;
      win_din    = win ? m1_din  : m0_din;
      win_be     = win ? m1_be   : m0_be;
      case (state)
         IDLE: begin
            if (boot) begin
               next_state = PCH;
               ret_next   = IDLE;
            end else if (ref_pend && row_open) begin
               next_state = PCH;
               ret_next   = REF;
            end else if (ref_pend) begin
               next_state = REF;
            end else if ((m0_req || m1_req) && !m0_ack && !m1_ack) begin
               grant = 1'b1;
               if (row_open && open_row == win_addr[19:8]) begin
                  next_state = win_rnw ? RD : WR;
               end else if (row_open) begin
                  next_state = PCH;
                  ret_next   = ACT;
               end else begin
                  next_state = ACT;
               end
            end
         end
         PCH:        if (wait_cnt == 4'd0) next_state = ret_state;
         ACT:        if (wait_cnt == 4'd0) next_state = lat_rnw ? RD : WR;
         RD, WR, REF: if (wait_cnt == 4'd0) next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      enter      = (next_state != state);
      done       = (state == RD || state == WR) && next_state == IDLE;
      cur_addr   = grant ? win_addr : lat_addr;
      cur_rnw    = grant ? win_rnw  : lat_rnw;
      cur_din    = grant ? win_din  : lat_din;
      cur_be     = grant ? win_be   : lat_be;
      wait_cnt_d = (wait_cnt != 4'd0) ? wait_cnt - 4'd1 : 4'd0;
      if (enter) begin
         case (next_state)
            PCH:     wait_cnt_d = 4'(T_PCH);
            ACT:     wait_cnt_d = 4'(T_ACT);
            RD:      wait_cnt_d = 4'(T_RD);
            WR:      wait_cnt_d = 4'(T_WR);
            REF:     wait_cnt_d = 4'(T_REF);
            default: wait_cnt_d = 4'd0;
         endcase
      end
   end

   // Command fields are loaded only on state entry so they stay put through each wait window.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         ch1_pch   <= 1'b0;
         ch1_act   <= 1'b0;
         ch1_reqr  <= 1'b0;
         ch1_reqw  <= 1'b0;
         ch1_ref   <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         wait_cnt  <= 4'd0;
         boot      <= 1'b1;
         last_gnt  <= 1'b1;
         gnt       <= 1'b0;
         lat_addr  <= 20'd0;
         lat_rnw   <= 1'b1;
         lat_din   <= 64'd0;
         lat_be    <= 8'd0;
         ch1_addr  <= 8'd0;
         ch1_caddr <= 13'd0;
         ch1_din   <= 64'd0;
         ch1_be    <= 8'd0;
         ch1_rnw   <= 1'b1;
         rd_data   <= 64'd0;
         row_open  <= 1'b0;
         open_row  <= 12'd0;
      end else begin
         ch1_pch  <= enter && next_state == PCH;
         ch1_act  <= enter && next_state == ACT;
         ch1_reqr <= enter && next_state == RD;
         ch1_reqw <= enter && next_state == WR;
         ch1_ref  <= enter && next_state == REF;
         m0_ack   <= done && !gnt;
         m1_ack   <= done && gnt;
         wait_cnt <= wait_cnt_d;
         if (state == IDLE) boot <= 1'b0;
         if (grant) begin
            lat_addr <= win_addr;
            lat_rnw  <= win_rnw;
            lat_din  <= win_din;
            lat_be   <= win_be;
            gnt      <= win;
            last_gnt <= win;
         end
         if (enter && next_state == PCH) row_open <= 1'b0;
         if (enter && next_state == ACT) begin
            ch1_caddr <= {1'b0, cur_addr[19:8]};
            row_open  <= 1'b1;
            open_row  <= cur_addr[19:8];
         end
         if (enter && (next_state == RD || next_state == WR)) begin
            ch1_addr  <= cur_addr[7:0];
            ch1_caddr <= {5'b0, cur_addr[7:0]};
            ch1_din   <= cur_din;
            ch1_be    <= cur_be;
            ch1_rnw   <= cur_rnw;
         end
         if (state == RD && next_state == IDLE) rd_data <= ch1_dout;
      end
   end

   // A wrap while a refresh is still pending merges into it; a wrap wins over the clear.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         ref_cnt  <= 10'd0;
         ref_pend <= 1'b0;
      end else begin
         if (ref_cnt == 10'(REF_INTERVAL - 1)) begin
            ref_cnt  <= 10'd0;
            ref_pend <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt + 10'd1;
            if (enter && next_state == REF) ref_pend <= 1'b0;
         end
      end
   end

endmodule
